// File: rtl/exc_pkg.sv
// Shared constants, state encoding and helpers for the exception scheduler.
package exc_pkg;

  localparam logic [4:0]  EXC_NONE = 5'h10;
  localparam logic [4:0]  EXC_ERET = 5'h11;
  localparam logic [4:0]  EXC_INT  = 5'h00;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hbfc00380;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    REDIRECT,
    DRAIN
  } state_t;

  // A delay-slot instruction restarts at its branch, one word earlier; wraps at 0.
  function automatic logic [31:0] epc_adjust(input logic [31:0] pc, input logic in_delay);
    return in_delay ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_sched_if.sv
// Pipeline-facing bundle of the exception scheduler: EX/CP0 inputs, CP0 commit, IF redirect.
interface exc_sched_if;

  logic [1:0]  ex_valid;
  logic [9:0]  ex_exc_code;
  logic [63:0] ex_pc;
  logic [1:0]  ex_in_delay;
  logic        int_req;
  logic [31:0] epc;
  logic        commit_valid;
  logic [4:0]  commit_code;
  logic [31:0] commit_epc;
  logic        commit_in_delay;
  logic        commit_slot;
  logic        flush_all;
  logic        stall_all;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        if_redirect_ready;
  logic        busy;

  // The pipeline side drives events and the IF ready.
  modport master (
    output ex_valid, ex_exc_code, ex_pc, ex_in_delay, int_req, epc, if_redirect_ready,
    input  commit_valid, commit_code, commit_epc, commit_in_delay, commit_slot,
    input  flush_all, stall_all, redirect_valid, redirect_addr, busy
  );

  modport slave (
    input  ex_valid, ex_exc_code, ex_pc, ex_in_delay, int_req, epc, if_redirect_ready,
    output commit_valid, commit_code, commit_epc, commit_in_delay, commit_slot,
    output flush_all, stall_all, redirect_valid, redirect_addr, busy
  );

endinterface

// File: rtl/exc_prio_sel.sv
// Combinational winner selection: interrupt on slot0, then slot0 event, then slot1 event.
module exc_prio_sel
  import exc_pkg::*;
(
  input  logic [1:0]  ex_valid,
  input  logic [9:0]  ex_exc_code,
  input  logic [63:0] ex_pc,
  input  logic [1:0]  ex_in_delay,
  input  logic        int_req,
  output logic        hit,
  output logic        slot,
  output logic [4:0]  code,
  output logic [31:0] pc,
  output logic        in_delay,
  output logic        is_eret
);

  logic [4:0] code0;
  logic [4:0] code1;

  assign code0 = ex_exc_code[4:0];
  assign code1 = ex_exc_code[9:5];

  // Interrupts ride on the oldest valid instruction; slot1 only wins when slot0 is clean.
  always_comb begin
    hit      = 1'b0;
    slot     = 1'b0;
    code     = EXC_NONE;
    pc       = ex_pc[31:0];
    in_delay = ex_in_delay[0];
    is_eret  = 1'b0;
    if (int_req && ex_valid[0]) begin
      hit  = 1'b1;
      code = EXC_INT;
    end else if (ex_valid[0] && (code0 != EXC_NONE)) begin
      hit     = 1'b1;
      code    = code0;
      is_eret = (code0 == EXC_ERET);
    end else if (ex_valid[1] && (code1 != EXC_NONE)) begin
      hit      = 1'b1;
      slot     = 1'b1;
      code     = code1;
      pc       = ex_pc[63:32];
      in_delay = ex_in_delay[1];
      is_eret  = (code1 == EXC_ERET);
    end
  end

endmodule

// File: rtl/exc_sched.sv
// Exception/interrupt scheduler: commit to CP0 with flush, redirect IF, then drain.
module exc_sched
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic         clk,
  input logic         rst_,
  exc_sched_if.slave  bus
);

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        capture;
  logic        sel_hit;
  logic        sel_slot;
  logic [4:0]  sel_code;
  logic [31:0] sel_pc;
  logic        sel_in_delay;
  logic        sel_is_eret;

  exc_prio_sel u_prio (
    .ex_valid    (bus.ex_valid),
    .ex_exc_code (bus.ex_exc_code),
    .ex_pc       (bus.ex_pc),
    .ex_in_delay (bus.ex_in_delay),
    .int_req     (bus.int_req),
    .hit         (sel_hit),
    .slot        (sel_slot),
    .code        (sel_code),
    .pc          (sel_pc),
    .in_delay    (sel_in_delay),
    .is_eret     (sel_is_eret)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_hit) begin
          state_next = COMMIT;
          capture    = 1'b1;
        end
      end
      COMMIT: state_next = REDIRECT;
      REDIRECT: begin
        if (bus.if_redirect_ready) begin
          if (DRAIN_INIT == 4'd0) begin
            state_next = IDLE;
          end else begin
            state_next = DRAIN;
            cnt_next   = DRAIN_INIT;
          end
        end
      end
      DRAIN: begin
        if (cnt <= 4'd1) state_next = IDLE;
        else             cnt_next   = cnt - 4'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every one of them leaves a flop.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state               <= IDLE;
      cnt                 <= 4'd0;
      bus.commit_valid    <= 1'b0;
      bus.flush_all       <= 1'b0;
      bus.stall_all       <= 1'b0;
      bus.redirect_valid  <= 1'b0;
      bus.busy            <= 1'b0;
      bus.commit_code     <= 5'd0;
      bus.commit_epc      <= 32'd0;
      bus.commit_in_delay <= 1'b0;
      bus.commit_slot     <= 1'b0;
      bus.redirect_addr   <= 32'd0;
    end else begin
      state              <= state_next;
      cnt                <= cnt_next;
      bus.commit_valid   <= (state_next == COMMIT);
      bus.flush_all      <= (state_next == COMMIT);
      bus.stall_all      <= (state_next != IDLE);
      bus.redirect_valid <= (state_next == REDIRECT);
      bus.busy           <= (state_next != IDLE);
      if (capture) begin
        bus.commit_code     <= sel_code;
        bus.commit_epc      <= epc_adjust(sel_pc, sel_in_delay);
        bus.commit_in_delay <= sel_in_delay;
        bus.commit_slot     <= sel_slot;
        bus.redirect_addr   <= sel_is_eret ? bus.epc : EXC_VECTOR;
      end
    end
  end

endmodule

// File: tb/tb_exc_sched.sv
// Directed self-checking bench for exc_sched with hand-computed expectations.
module tb_exc_sched;
  import exc_pkg::*;

  localparam logic [31:0] VEC = 32'hbfc00380;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  int   check_count = 0;
  int   error_count = 0;
  int   commits, stalls, rvs;

  always #5 clk = ~clk;

  exc_sched_if bus();

  exc_sched #(.EXC_VECTOR(VEC), .DRAIN_CYCLES(2)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [4:0] c0, input logic [4:0] c1,
                               input logic [31:0] p0, input logic [31:0] p1, input logic [1:0] dly,
                               input logic intr, input logic [31:0] epc_v);
    bus.ex_valid    = valid;
    bus.ex_exc_code = {c1, c0};
    bus.ex_pc       = {p1, p0};
    bus.ex_in_delay = dly;
    bus.int_req     = intr;
    bus.epc         = epc_v;
  endtask

  task automatic clearStimulus();
    applyStimulus(2'b00, EXC_NONE, EXC_NONE, 32'd0, 32'd0, 2'b00, 1'b0, 32'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_commit_valid"}, 32'(bus.commit_valid), 32'd0);
    checkOutput({tag, "_commit_code"}, 32'(bus.commit_code), 32'd0);
    checkOutput({tag, "_commit_epc"}, bus.commit_epc, 32'd0);
    checkOutput({tag, "_commit_in_delay"}, 32'(bus.commit_in_delay), 32'd0);
    checkOutput({tag, "_commit_slot"}, 32'(bus.commit_slot), 32'd0);
    checkOutput({tag, "_flush_all"}, 32'(bus.flush_all), 32'd0);
    checkOutput({tag, "_stall_all"}, 32'(bus.stall_all), 32'd0);
    checkOutput({tag, "_redirect_valid"}, 32'(bus.redirect_valid), 32'd0);
    checkOutput({tag, "_redirect_addr"}, bus.redirect_addr, 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Starts in the COMMIT cycle; IF ready rises once redirect_valid has been seen ready_delay times.
  task automatic runSequence(input int ready_delay, input logic [31:0] exp_addr,
                             output int n_commit, output int n_stall, output int n_rv);
    int  rv_seen;
    logic done;
    n_commit = 0;
    n_stall  = 0;
    n_rv     = 0;
    rv_seen  = 0;
    done     = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      if (bus.commit_valid) n_commit++;
      if (bus.stall_all) n_stall++;
      if (bus.redirect_valid) begin
        n_rv++;
        rv_seen++;
        checkOutput("redirect_addr", bus.redirect_addr, exp_addr);
      end
      bus.if_redirect_ready = (rv_seen >= ready_delay);
      tick();
    end
    if (!done) checkOutput("sequence_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    clearStimulus();
    bus.if_redirect_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkIdleOutputs("reset");
    rst_ = 1'b1;
    tick();

    // Slot0 exception with exact per-cycle latency checks.
    applyStimulus(2'b01, 5'h0a, EXC_NONE, 32'h80001000, 32'd0, 2'b00, 1'b0, 32'd0);
    tick();
    clearStimulus();
    checkOutput("t1_commit_valid", 32'(bus.commit_valid), 32'd1);
    checkOutput("t1_flush_all", 32'(bus.flush_all), 32'd1);
    checkOutput("t1_redirect_early", 32'(bus.redirect_valid), 32'd0);
    checkOutput("t1_commit_code", 32'(bus.commit_code), 32'h0a);
    checkOutput("t1_commit_epc", bus.commit_epc, 32'h80001000);
    checkOutput("t1_commit_slot", 32'(bus.commit_slot), 32'd0);
    tick();
    checkOutput("t1_commit_pulse", 32'(bus.commit_valid), 32'd0);
    checkOutput("t1_redirect_valid", 32'(bus.redirect_valid), 32'd1);
    checkOutput("t1_redirect_addr", bus.redirect_addr, VEC);
    tick();
    checkOutput("t1_drain1_rv", 32'(bus.redirect_valid), 32'd0);
    checkOutput("t1_drain1_stall", 32'(bus.stall_all), 32'd1);
    tick();
    checkOutput("t1_drain2_stall", 32'(bus.stall_all), 32'd1);
    tick();
    checkOutput("t1_idle_stall", 32'(bus.stall_all), 32'd0);
    checkOutput("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Back-to-back: both slots busy, slot0 is older and wins.
    applyStimulus(2'b11, 5'h0b, 5'h0c, 32'h80001100, 32'h80001104, 2'b00, 1'b0, 32'd0);
    tick();
    clearStimulus();
    checkOutput("b2b_commit_valid", 32'(bus.commit_valid), 32'd1);
    checkOutput("b2b_commit_code", 32'(bus.commit_code), 32'h0b);
    checkOutput("b2b_commit_slot", 32'(bus.commit_slot), 32'd0);
    runSequence(1, VEC, commits, stalls, rvs);
    checkOutput("b2b_stalls", 32'(stalls), 32'd4);

    // Slot1 exception in a delay slot.
    applyStimulus(2'b11, EXC_NONE, 5'h0c, 32'h80001ff0, 32'h80002004, 2'b10, 1'b0, 32'd0);
    tick();
    clearStimulus();
    checkOutput("t2_commit_code", 32'(bus.commit_code), 32'h0c);
    checkOutput("t2_commit_slot", 32'(bus.commit_slot), 32'd1);
    checkOutput("t2_commit_epc", bus.commit_epc, 32'h80002000);
    checkOutput("t2_commit_in_delay", 32'(bus.commit_in_delay), 32'd1);
    runSequence(1, VEC, commits, stalls, rvs);

    // Interrupt beats both exceptions; inputs held to show they are ignored while busy.
    applyStimulus(2'b11, 5'h04, 5'h05, 32'h80004000, 32'h80004004, 2'b00, 1'b1, 32'd0);
    tick();
    checkOutput("t3_commit_code", 32'(bus.commit_code), 32'h00);
    checkOutput("t3_commit_slot", 32'(bus.commit_slot), 32'd0);
    checkOutput("t3_commit_epc", bus.commit_epc, 32'h80004000);
    runSequence(1, VEC, commits, stalls, rvs);
    clearStimulus();
    checkOutput("t3_commit_count", 32'(commits), 32'd1);

    // ERET: target is the sampled epc, IF stalls the handshake for three cycles.
    applyStimulus(2'b01, EXC_ERET, EXC_NONE, 32'h80005000, 32'd0, 2'b00, 1'b0, 32'h80003000);
    tick();
    clearStimulus();
    checkOutput("t4_commit_code", 32'(bus.commit_code), 32'h11);
    checkOutput("t4_commit_epc", bus.commit_epc, 32'h80005000);
    runSequence(3, 32'h80003000, commits, stalls, rvs);
    checkOutput("t4_rv_cycles", 32'(rvs), 32'd3);
    checkOutput("t4_stall_cycles", 32'(stalls), 32'd6);
    checkOutput("t4_commit_count", 32'(commits), 32'd1);

    // Interrupt without a valid slot0 waits, and invalid codes are ignored.
    applyStimulus(2'b00, 5'h0a, 5'h0c, 32'h80006000, 32'h80006004, 2'b00, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t5_wait_commit", 32'(bus.commit_valid), 32'd0);
      checkOutput("t5_wait_busy", 32'(bus.busy), 32'd0);
    end
    bus.ex_valid = 2'b01;
    tick();
    clearStimulus();
    checkOutput("t5_commit_valid", 32'(bus.commit_valid), 32'd1);
    checkOutput("t5_commit_code", 32'(bus.commit_code), 32'h00);
    checkOutput("t5_commit_epc", bus.commit_epc, 32'h80006000);
    runSequence(1, VEC, commits, stalls, rvs);

    // Reset during REDIRECT aborts everything at once.
    bus.if_redirect_ready = 1'b0;
    applyStimulus(2'b01, 5'h07, EXC_NONE, 32'h80007000, 32'd0, 2'b00, 1'b0, 32'd0);
    tick();
    clearStimulus();
    tick();
    checkOutput("t6_in_redirect", 32'(bus.redirect_valid), 32'd1);
    rst_ = 1'b0;
    #1;
    checkIdleOutputs("t6_abort");
    tick();
    rst_ = 1'b1;
    tick();
    checkOutput("t6_after_release_busy", 32'(bus.busy), 32'd0);
    bus.if_redirect_ready = 1'b1;
    applyStimulus(2'b01, 5'h05, EXC_NONE, 32'h00000000, 32'd0, 2'b01, 1'b0, 32'd0);
    tick();
    clearStimulus();
    checkOutput("t6_commit_valid", 32'(bus.commit_valid), 32'd1);
    checkOutput("t6_commit_epc_wrap", bus.commit_epc, 32'hfffffffc);
    checkOutput("t6_commit_in_delay", 32'(bus.commit_in_delay), 32'd1);
    runSequence(1, VEC, commits, stalls, rvs);
    checkOutput("t6_stall_cycles", 32'(stalls), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/exc_sched.md
# exc_sched

Exception/interrupt scheduler for the dual-issue pipeline. It takes per-slot exception codes from EX and a pre-qualified interrupt request from CP0, and picks exactly one winning event. It then sequences the response: a one-cycle commit to CP0 with a global flush, a redirect handshake with IF, and a programmable drain/stall window that lets in-flight I-cache fetches retire before normal issue resumes.

## Interface
Parameters:
- EXC_VECTOR, 32'hbfc00380: redirect target for all exceptions and interrupts.
- DRAIN_CYCLES, 2: stall cycles after the IF redirect handshake; legal range 0..15.

Ports:
- clk  in  1  system clock.
- rst_  in  1  reset, asynchronous, active-low.
- ex_valid  in  2  bit i set = slot i holds a real instruction.
- ex_exc_code  in  10  [4:0] slot0, [9:5] slot1. 5'h10 = none, 5'h11 = ERET, any other value = exception code.
- ex_pc  in  64  [31:0] slot0 PC, [63:32] slot1 PC.
- ex_in_delay  in  2  slot i is in a branch delay slot.
- int_req  in  1  interrupt pending and enabled (level, qualified by CP0).
- epc  in  32  current CP0 EPC, used as the ERET target.
- commit_valid  out  1  one-cycle pulse: CP0 applies the commit_* fields.
- commit_code  out  5  winning code (5'h00 for an interrupt).
- commit_epc  out  32  commit_in_delay ? pc-4 : pc.
- commit_in_delay  out  1  winner was in a delay slot.
- commit_slot  out  1  winning slot.
- flush_all  out  1  flushes all stages; coincident with commit_valid.
- stall_all  out  1  freezes PC/issue while redirecting and draining.
- redirect_valid  out  1  redirect request to IF.
- redirect_addr  out  32  redirect target; stable while redirect_valid is high.
- if_redirect_ready  in  1  IF accepts the redirect.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, COMMIT, REDIRECT, DRAIN.
- Winner selection (combinational, evaluated in IDLE only), priority order:
  - int_req && ex_valid[0] → interrupt, slot0 PC.
  - ex_valid[0] && code0 != 5'h10 → slot0 event.
  - ex_valid[1] && code1 != 5'h10 → slot1 event.
- Slot1 never wins while slot0 has an event, because slot1 is younger.
- int_req with ex_valid[0]=0 is not accepted; it stays pending (level) and is taken on the next valid slot0.
- A code is ignored when its ex_valid bit is 0.
- IDLE → COMMIT when a winner exists. The winner's code, epc, in_delay, slot and target are registered. Target = epc input (sampled at that edge) for ERET; EXC_VECTOR otherwise.
- COMMIT: commit_valid=1, flush_all=1, stall_all=1 for exactly one cycle, then → REDIRECT.
- REDIRECT: redirect_valid=1, stall_all=1. Leave on if_redirect_ready=1: → DRAIN with the counter loaded to DRAIN_CYCLES, or → IDLE if DRAIN_CYCLES=0.
- DRAIN: stall_all=1, counter decrements each cycle; when the counter reaches 1 → IDLE.
- All ex_* and int_req inputs are ignored outside IDLE; the pipeline is being flushed, so nothing is lost.
- commit_epc is computed with 32-bit wraparound subtraction (pc=0 in a delay slot gives 32'hfffffffc).

## Timing
- Reset (async assert, sync release): state=IDLE; every output 0, including redirect_addr and all commit_* fields.
- Reset asserted mid-sequence aborts immediately. No partial commit or redirect survives.
- All outputs are registered. Latency from winner-present edge:
  - commit_valid/flush_all: 1 cycle.
  - redirect_valid: 2 cycles.
- Earliest next acceptance: DRAIN_CYCLES + 3 cycles after the accepting edge, with ready held high.
- if_redirect_ready may be high before redirect_valid; it is sampled only in REDIRECT. Minimum redirect_valid width is 1 cycle.
- Back-to-back: a winner present on the cycle the FSM returns to IDLE is accepted on the next edge. No bubble is required beyond IDLE.

## Structure
- Package exc_pkg:
  - EXC_NONE=5'h10, EXC_ERET=5'h11, EXC_INT=5'h00.
  - State enum, 2 bits.
  - Default vector constant.
- Sub-module exc_prio_sel: combinational winner selection. Outputs hit, slot, code, pc, in_delay, is_eret.
- The FSM, capture registers and drain counter live in exc_sched.

## Test plan
- Slot0 code 5'h0a, pc 32'h80001000, no delay → commit_code 5'h0a, commit_epc 32'h80001000, redirect_addr 32'hbfc00380 two cycles later.
- Slot0 none, slot1 code 5'h0c, pc 32'h80002004, in_delay=2'b10 → commit_slot 1, commit_epc 32'h80002000.
- Both slots have exceptions and int_req=1 → exactly one commit, code 5'h00, slot 0.
- Slot0 ERET with epc=32'h80003000; IF ready delayed 3 cycles → redirect_valid held 3 cycles, then 2 drain cycles; stall_all high for exactly 6 cycles total.
- int_req=1 with ex_valid=2'b00 for 4 cycles → no commit; ex_valid[0] rises → commit on the next cycle.
- rst_ asserted during REDIRECT → all outputs 0 immediately; new exception after release is handled normally.
